// File: rtl/frame_buffer_writer.sv
// -----------------------------------------------------------------------------
// frame_buffer_writer
//
// Write side of the frame memory. Captures exactly one raster frame per start
// command from a valid/ready pixel stream and turns every accepted pixel into
// a single-cycle write (strobe, sequential address, data) for a single-port
// RAM. The read side later sweeps the same addresses upward, so pixels land at
// consecutive addresses in raster order starting at 0.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   start        begin capturing one frame (sampled only when idle)
//   abort        cancel the frame in progress (only honoured while writing)
//   pixel_valid  pixel_data carries a pixel
//   pixel_data   incoming pixel
//   pixel_ready  writer accepts a pixel this cycle
//   wr_enable    RAM write strobe, one cycle after the accept
//   wr_address   RAM write address (held while wr_enable is low)
//   wr_data      RAM write data (held while wr_enable is low)
//   busy         frame capture in progress
//   frame_done   one-cycle pulse in the cycle after the last write strobe
//   row, col     raster position of the next pixel to accept
//   frame_count  completed frames, wraps
// -----------------------------------------------------------------------------
module frame_buffer_writer #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FRAME_WIDTH  = 64,
    parameter int unsigned FRAME_HEIGHT = 64,
    parameter int unsigned COUNT_WIDTH  = 8,
    localparam int unsigned RowWidth    = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1,
    localparam int unsigned ColWidth    = $clog2(FRAME_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   pixel_valid,
    input  logic [DATA_WIDTH-1:0]  pixel_data,
    output logic                   pixel_ready,
    output logic                   wr_enable,
    output logic [ADDR_WIDTH-1:0]  wr_address,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic [RowWidth-1:0]    row,
    output logic [ColWidth-1:0]    col,
    output logic [COUNT_WIDTH-1:0] frame_count
);

    localparam logic [ColWidth-1:0] ColLast = ColWidth'(FRAME_WIDTH - 1);
    localparam logic [RowWidth-1:0] RowLast = RowWidth'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e                 state_q;
    logic [RowWidth-1:0]    row_q;
    logic [ColWidth-1:0]    col_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   wr_enable_q;
    logic [ADDR_WIDTH-1:0]  wr_address_q;
    logic [DATA_WIDTH-1:0]  wr_data_q;
    logic                   frame_done_q;
    logic [COUNT_WIDTH-1:0] frame_count_q;

    logic last_pixel;

    // Position of the final pixel; accepting it ends the frame. Counters are
    // cleared at that point rather than stepped, so the address never runs
    // past the last pixel even when the frame fills the whole address space.
    assign last_pixel = (row_q == RowLast) && (col_q == ColLast);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            row_q         <= '0;
            col_q         <= '0;
            addr_q        <= '0;
            wr_enable_q   <= 1'b0;
            wr_address_q  <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            // Strobes default low; address and data hold their last values.
            wr_enable_q  <= 1'b0;
            frame_done_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StWrite;
                        row_q   <= '0;
                        col_q   <= '0;
                        addr_q  <= '0;
                    end
                end

                StWrite: begin
                    if (abort) begin
                        // Abort beats a simultaneous accept: that pixel is dropped.
                        state_q <= StIdle;
                        row_q   <= '0;
                        col_q   <= '0;
                        addr_q  <= '0;
                    end else if (pixel_valid) begin
                        wr_enable_q  <= 1'b1;
                        wr_address_q <= addr_q;
                        wr_data_q    <= pixel_data;
                        if (last_pixel) begin
                            state_q <= StDone;
                            row_q   <= '0;
                            col_q   <= '0;
                            addr_q  <= '0;
                        end else begin
                            addr_q <= addr_q + ADDR_WIDTH'(1);
                            if (col_q == ColLast) begin
                                col_q <= '0;
                                row_q <= row_q + RowWidth'(1);
                            end else begin
                                col_q <= col_q + ColWidth'(1);
                            end
                        end
                    end
                end

                StDone: begin
                    // Single cycle covering the final write strobe.
                    state_q       <= StIdle;
                    frame_done_q  <= 1'b1;
                    frame_count_q <= frame_count_q + COUNT_WIDTH'(1);
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Handshake and status decode straight from the state register.
    assign pixel_ready = (state_q == StWrite);
    assign busy        = (state_q != StIdle);

    assign wr_enable   = wr_enable_q;
    assign wr_address  = wr_address_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign row         = row_q;
    assign col         = col_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
module tb_frame_buffer_writer;

    localparam int FW  = 4;
    localparam int FH  = 2;
    localparam int AW  = 3;
    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int PIX = FW * FH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pixel_valid = 1'b0;
    logic [DW-1:0] pixel_data = '0;
    logic          pixel_ready;
    logic          wr_enable;
    logic [AW-1:0] wr_address;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          frame_done;
    logic [0:0]    row;
    logic [1:0]    col;
    logic [CW-1:0] frame_count;

    frame_buffer_writer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .abort      (abort),
        .pixel_valid(pixel_valid),
        .pixel_data (pixel_data),
        .pixel_ready(pixel_ready),
        .wr_enable  (wr_enable),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .row        (row),
        .col        (col),
        .frame_count(frame_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 = idle, 1 = capturing, 2 = finishing.
    // n = pixels accepted so far in the current frame.
    int            m_phase = 0;
    int            m_n     = 0;
    logic          m_we    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    logic          m_done  = 1'b0;
    logic [CW-1:0] m_count = '0;

    logic [25:0] obs;
    assign obs = {wr_enable, wr_address, wr_data, frame_done, busy, pixel_ready, row, col,
                  frame_count};

    function automatic logic [25:0] expv();
        logic [0:0] r;
        logic [1:0] c;
        logic       b;
        logic       rd;
        r  = 1'(m_n / FW);
        c  = 2'(m_n % FW);
        b  = (m_phase != 0);
        rd = (m_phase == 1);
        return {m_we, m_addr, m_data, m_done, b, rd, r, c, m_count};
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, settle past it.
    task automatic drive(input logic s, input logic a, input logic v, input logic [DW-1:0] d);
        start       = s;
        abort       = a;
        pixel_valid = v;
        pixel_data  = d;
        @(posedge clk);
        if (!rst_n) begin
            m_phase = 0; m_n = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
            m_done = 1'b0; m_count = '0;
        end else begin
            m_we   = 1'b0;
            m_done = 1'b0;
            case (m_phase)
                0: if (s) begin m_phase = 1; m_n = 0; end
                1: begin
                    if (a) begin
                        m_phase = 0; m_n = 0;
                    end else if (v) begin
                        m_we = 1'b1; m_addr = AW'(m_n); m_data = d;
                        m_n = m_n + 1;
                        if (m_n == PIX) begin m_phase = 2; m_n = 0; end
                    end
                end
                default: begin m_phase = 0; m_done = 1'b1; m_count = m_count + 1'b1; end
            endcase
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            total++;
            if (obs !== 26'd0) begin
                bad++; $display("FAIL reset cyc=%0d got=%h want=0", i, obs);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'($urandom), 1'b1, 8'($urandom));
            total++;
            if (obs !== expv() || wr_enable !== 1'b0 || pixel_ready !== 1'b0) begin
                bad++; $display("FAIL idle_valid cyc=%0d got=%h want=%h", i, obs, expv());
            end
        end
    endtask

    task automatic test_full_frame();
        int writes = 0;
        int dones  = 0;
        drive(1'b1, 1'b0, 1'b1, 8'hEE);
        total++;
        if (obs !== expv() || pixel_ready !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL full_frame_start got=%h want=%h", obs, expv());
        end
        for (int i = 0; i < PIX + 3; i++) begin
            if (i < PIX) drive(1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
            else         drive(1'b0, 1'b0, 1'b0, 8'h00);
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL full_frame cyc=%0d got=%h want=%h", i, obs, expv());
            end
            if (wr_enable === 1'b1) begin
                total++;
                if (wr_address !== AW'(writes) || wr_data !== 8'(8'h10 + writes)) begin
                    bad++;
                    $display("FAIL full_frame_write n=%0d got=%0d/%h want=%0d/%h", writes,
                             wr_address, wr_data, writes, 8'(8'h10 + writes));
                end
                writes++;
            end
            if (frame_done === 1'b1) begin
                total++;
                if (i != PIX) begin
                    bad++; $display("FAIL full_frame_done_timing got=%0d want=%0d", i, PIX);
                end
                dones++;
            end
        end
        total++;
        if (writes != PIX || dones != 1 || frame_count !== 8'd1 || busy !== 1'b0
            || pixel_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_frame_end got w=%0d d=%0d cnt=%0d want w=8 d=1 cnt=1",
                     writes, dones, frame_count);
        end
    endtask

    task automatic test_stalled();
        int writes = 0;
        int cyc    = 0;
        drive(1'b1, 1'b0, 1'b0, '0);
        while (m_phase != 0 && cyc < 100) begin
            drive(1'b0, 1'b0, 1'(cyc % 3 == 0), 8'($urandom));
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL stalled cyc=%0d got=%h want=%h", cyc, obs, expv());
            end
            if (wr_enable === 1'b1) begin
                total++;
                if (wr_address !== AW'(writes)) begin
                    bad++; $display("FAIL stalled_addr got=%0d want=%0d", wr_address, writes);
                end
                writes++;
            end
            cyc++;
        end
        total++;
        if (writes != PIX || cyc >= 100) begin
            bad++; $display("FAIL stalled_count got=%0d want=%0d cyc=%0d", writes, PIX, cyc);
        end
    endtask

    task automatic test_extra_pixels();
        int writes = 0;
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            if (i >= PIX) begin
                total++;
                if (pixel_ready !== 1'b0) begin
                    bad++; $display("FAIL extra_ready pix=%0d got=%b want=0", i + 1, pixel_ready);
                end
            end
            drive(1'b0, 1'b0, 1'b1, 8'($urandom));
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL extra cyc=%0d got=%h want=%h", i, obs, expv());
            end
            if (wr_enable === 1'b1) writes++;
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        total++;
        if (writes != PIX || wr_enable !== 1'b0) begin
            bad++; $display("FAIL extra_count got=%0d want=%0d", writes, PIX);
        end
    endtask

    task automatic test_abort();
        int            writes = 0;
        int            dones  = 0;
        logic [CW-1:0] cnt0;
        cnt0 = frame_count;
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'(i == 2), 1'(i < 3), 8'($urandom));
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL abort cyc=%0d got=%h want=%h", i, obs, expv());
            end
            if (wr_enable === 1'b1) writes++;
            if (frame_done === 1'b1) dones++;
        end
        total++;
        if (writes != 2 || dones != 0 || frame_count !== cnt0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_end got w=%0d d=%0d cnt=%0d want w=2 d=0 cnt=%0d",
                     writes, dones, frame_count, cnt0);
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 8'h5A);
        total++;
        if (obs !== expv() || wr_enable !== 1'b1 || wr_address !== 3'd0) begin
            bad++; $display("FAIL abort_restart got=%h want=%h", obs, expv());
        end
        for (int i = 0; i < PIX + 2; i++) drive(1'b0, 1'b0, 1'b1, 8'($urandom));
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 8'($urandom));
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 8'($urandom));
        total++;
        if (obs !== 26'd0) begin
            bad++; $display("FAIL reset_mid got=%h want=0", obs);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 8'hA5);
        total++;
        if (obs !== expv() || wr_address !== 3'd0 || frame_count !== 8'd0) begin
            bad++; $display("FAIL reset_mid_restart got=%h want=%h", obs, expv());
        end
        for (int i = 0; i < PIX + 2; i++) drive(1'b0, 1'b0, 1'b1, 8'($urandom));
    endtask

    task automatic test_random_stream();
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0),
                  1'($urandom), 8'($urandom));
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, expv());
            end
        end
    endtask

    task automatic test_back_to_back();
        int writes = 0;
        int dones  = 0;
        int cyc    = 0;
        do_reset();
        while (dones < 2 && cyc < 100) begin
            drive(1'b1, 1'b0, 1'b1, 8'($urandom));
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, obs, expv());
            end
            if (wr_enable === 1'b1) begin
                total++;
                if (wr_address !== AW'(writes % PIX)) begin
                    bad++; $display("FAIL b2b_addr got=%0d want=%0d", wr_address, writes % PIX);
                end
                writes++;
            end
            if (frame_done === 1'b1) dones++;
            cyc++;
        end
        total++;
        if (writes != 2 * PIX || frame_count !== 8'd2) begin
            bad++; $display("FAIL b2b_two got w=%0d cnt=%0d want w=16 cnt=2", writes, frame_count);
        end
        // Immediate restart: the cycle after frame_done is already capturing.
        drive(1'b1, 1'b0, 1'b1, 8'($urandom));
        total++;
        if (pixel_ready !== 1'b1 || obs !== expv()) begin
            bad++; $display("FAIL b2b_restart got=%h want=%h", obs, expv());
        end
        cyc = 0;
        while (dones < 256 && cyc < 4000) begin
            drive(1'b1, 1'b0, 1'b1, 8'($urandom));
            if (frame_done === 1'b1) dones++;
            cyc++;
        end
        total++;
        if (dones != 256 || frame_count !== 8'd0 || obs !== expv()) begin
            bad++; $display("FAIL wrap got d=%0d cnt=%0d want d=256 cnt=0", dones, frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_idle_valid();
        test_full_frame();
        test_stalled();
        test_extra_pixels();
        test_abort();
        test_reset_mid_frame();
        test_random_stream();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Write side of the frame memory: accepts a raster pixel stream over a valid/ready handshake and generates sequential write strobes, addresses and data for the single-port RAM.
- The rom read path later consumes the same memory by sweeping addresses upward.
- Sits between the camera/pixel front end and the frame memory.
- Writes exactly one frame per start command, then reports completion.

Parameters:
- ADDR_WIDTH, 12, width of RAM write address; FRAME_WIDTH*FRAME_HEIGHT must be <= 2^ADDR_WIDTH.
- DATA_WIDTH, 8, pixel/RAM data width.
- FRAME_WIDTH, 64, pixels per row (>=2).
- FRAME_HEIGHT, 64, rows per frame (>=1).
- COUNT_WIDTH, 8, width of completed-frame counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin capturing one frame; sampled only in IDLE.
- abort  in  1  cancel frame in progress.
- pixel_valid  in  1  pixel_data is valid.
- pixel_data  in  DATA_WIDTH  incoming pixel.
- pixel_ready  out  1  writer accepts a pixel this cycle.
- wr_enable  out  1  RAM write strobe.
- wr_address  out  ADDR_WIDTH  RAM write address.
- wr_data  out  DATA_WIDTH  RAM write data.
- busy  out  1  frame capture in progress.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
- row  out  log2(FRAME_HEIGHT)  row of next pixel to accept.
- col  out  log2(FRAME_WIDTH)  column of next pixel to accept.
- frame_count  out  COUNT_WIDTH  completed frames, wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs 0; internal address counter 0. Reset wins over every other input, including mid-frame. A partially written frame is not completed, and frame_count is not incremented.
- States: IDLE, WRITE, DONE.
- IDLE:
  - pixel_ready=0 and busy=0.
  - start==1 -> WRITE; row, col and address counter are cleared.
  - pixel_valid is ignored.
- WRITE:
  - pixel_ready=1 and busy=1 (both decoded from the state register).
  - Accept occurs when pixel_valid && pixel_ready at a posedge.
  - Latency is one cycle: in the cycle following an accept, wr_enable=1, wr_data=accepted pixel and wr_address=address counter value at accept.
  - Address counter increments by 1 per accept; no multiplier is used.
  - col increments per accept. At col==FRAME_WIDTH-1, col wraps to 0 and row increments.
  - Accepting the last pixel (row==FRAME_HEIGHT-1, col==FRAME_WIDTH-1) -> DONE. pixel_ready is 0 from the next cycle, so at most FRAME_WIDTH*FRAME_HEIGHT pixels are accepted.
  - Cycles with pixel_valid==0 produce wr_enable=0. Back-to-back accepts produce back-to-back strobes.
- DONE: lasts exactly one cycle. On exit:
  - frame_done=1 for one cycle, coinciding with the cycle after the last wr_enable.
  - frame_count increments.
  - busy drops.
  - state -> IDLE.
- abort==1 in WRITE:
  - -> IDLE with counters cleared; no frame_done; frame_count unchanged.
  - Abort has priority over a simultaneous accept: that pixel produces no write.
  - A write strobe already registered from the previous accept still completes.
  - abort is ignored in IDLE and DONE.
- start is ignored in WRITE and DONE. A start in the frame_done cycle (state IDLE) begins a new frame.
- When wr_enable==0, wr_address and wr_data hold their last values.
- row, col and address counter all reset to 0 at the start of every frame; the address never exceeds FRAME_WIDTH*FRAME_HEIGHT-1.

Test Plan:
- Setup for all scenarios: FRAME_WIDTH=4, FRAME_HEIGHT=2, ADDR_WIDTH=3.
- Full frame: start, then 8 continuous pixels 0x10..0x17 -> wr_enable high 8 cycles, addresses 0..7 with data 0x10..0x17; frame_done pulse on the cycle after address 7; frame_count=1; busy=0; pixel_ready=0 afterwards.
- Stalled stream: pixel_valid toggled 1,0,0,1,... -> exactly 8 writes, addresses contiguous 0..7, no strobe on idle cycles; row/col step (0,1),(0,2),(0,3),(1,0)... only on accepts.
- Extra pixels and ignored inputs:
  - 10 pixels offered -> only 8 accepted; pixels 9 and 10 see pixel_ready=0 and produce no writes.
  - pixel_valid during IDLE before start -> no writes.
- Abort: abort asserted together with the 3rd accept -> 2 writes only (addresses 0,1); no frame_done; frame_count unchanged. Next start writes from address 0.
- Reset mid-frame: reset low after 5 accepts -> next cycle all outputs 0 and state IDLE. A new frame restarts at address 0; frame_count=0.
- Back-to-back frames: start held high through frame_done -> second frame begins immediately; addresses 0..7 again; frame_count reaches 2, then wrap is checked by forcing 256 frames -> frame_count=0.
